pcap_frame_extract: RTL and testbench

// - Upstream feeder of the UDP top's input FIFO: consumes a raw libpcap byte stream
//   (file-reader/testbench source) and strips the 24B global header and each 16B record header.
// - Writes each captured Ethernet frame into the input FIFO write port, framed with sof/eof.
// - Records longer than MAX_LEN are consumed and dropped, never written.

---
 rtl/pcap_frame_extract.sv | 161 ++++++++++++++++
 tb/tb_pcap_frame_extract.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcap_frame_extract.sv
`default_nettype none
// ============================================================================
//  Module      : pcap_frame_extract
//  Description : Strips the libpcap global header (24 B) and per-record
//                headers (16 B) from a raw pcap byte stream and writes each
//                captured Ethernet frame into a FIFO write port, marked with
//                sof/eof. Records with incl_len > MAX_LEN are consumed and
//                dropped. A bad global magic latches hdr_error until reset.
//                Optional statistics counters: define PCAP_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module pcap_frame_extract #(
    parameter int MAX_LEN = 1518,
    parameter int LEN_W   = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       out_wr_en,
    output logic [7:0] out_din,
    output logic       out_wr_sof,
    output logic       out_wr_eof,
    input  logic       out_full,
    output logic       hdr_error
`ifdef PCAP_STATS_EN
    ,
    output logic [15:0] pkt_count,
    output logic [15:0] drop_count
`endif
);

    localparam logic [1:0] S_GLOBAL_HDR = 2'd0;
    localparam logic [1:0] S_REC_HDR    = 2'd1;
    localparam logic [1:0] S_PAYLOAD    = 2'd2;
    localparam logic [1:0] S_ERROR      = 2'd3;

    // Magic as it appears on the wire: byte 0 is the least significant byte
    localparam logic [31:0] c_magic      = 32'hA1B2C3D4;
    localparam logic [4:0]  c_glb_last   = 5'd23;
    localparam logic [4:0]  c_rec_last   = 5'd15;
    localparam logic [LEN_W-1:0] c_max_len = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] c_one     = LEN_W'(1);

    logic [1:0]       r_state;
    logic [4:0]       r_byte_cnt;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_remaining;
    logic             r_drop;
    logic             r_hdr_error;

    logic             w_accept;
    logic             w_fwd;
    logic [7:0]       w_magic_byte;
    logic [LEN_W-1:0] w_len_byte;
    logic             w_len_over;
    logic             w_rec_done;

    // Backpressure only matters while actually forwarding; dropped records,
    // headers and the error state always sink bytes. Reset forces ready high
    // and suppresses writes regardless of the (not yet cleared) state.
    assign w_fwd      = (r_state == S_PAYLOAD) && !r_drop;
    assign in_ready   = !(reset && w_fwd && out_full);
    assign w_accept   = in_valid && in_ready;
    assign out_din    = in_data;
    assign out_wr_en  = reset && w_accept && w_fwd;
    assign out_wr_sof = out_wr_en && (r_remaining == r_len);
    assign out_wr_eof = out_wr_en && (r_remaining == c_one);
    assign hdr_error  = r_hdr_error;

    // Expected magic byte for global header offsets 0..3
    assign w_magic_byte = c_magic[{r_byte_cnt[1:0], 3'b000} +: 8];

    // incl_len occupies record header offsets 8..11, little-endian
    assign w_len_byte = LEN_W'(in_data) << {r_byte_cnt[1:0], 3'b000};
    assign w_len_over = (r_len > c_max_len);
    assign w_rec_done = (r_state == S_REC_HDR) && (r_byte_cnt == c_rec_last);

    // Parser state machine; advances only on an accepted byte
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_GLOBAL_HDR;
            r_byte_cnt  <= 5'd0;
            r_len       <= '0;
            r_remaining <= '0;
            r_drop      <= 1'b0;
            r_hdr_error <= 1'b0;
        end else if (w_accept) begin
            case (r_state)
                S_GLOBAL_HDR: begin
                    if ((r_byte_cnt < 5'd4) && (in_data != w_magic_byte)) begin
                        r_state     <= S_ERROR;
                        r_hdr_error <= 1'b1;
                    end else if (r_byte_cnt == c_glb_last) begin
                        r_state    <= S_REC_HDR;
                        r_byte_cnt <= 5'd0;
                    end else begin
                        r_byte_cnt <= r_byte_cnt + 5'd1;
                    end
                end
                S_REC_HDR: begin
                    if (r_byte_cnt == 5'd8) begin
                        r_len <= w_len_byte;
                    end else if ((r_byte_cnt > 5'd8) && (r_byte_cnt < 5'd12)) begin
                        r_len <= r_len | w_len_byte;
                    end
                    if (r_byte_cnt == c_rec_last) begin
                        r_byte_cnt <= 5'd0;
                        // Zero-length records carry no payload: stay for the next header
                        if (r_len != '0) begin
                            r_state     <= S_PAYLOAD;
                            r_remaining <= r_len;
                            r_drop      <= w_len_over;
                        end
                    end else begin
                        r_byte_cnt <= r_byte_cnt + 5'd1;
                    end
                end
                S_PAYLOAD: begin
                    r_remaining <= r_remaining - c_one;
                    if (r_remaining == c_one) begin
                        r_state <= S_REC_HDR;
                        r_drop  <= 1'b0;
                    end
                end
                default: begin
                    // Error is terminal until reset; bytes are silently sunk
                    r_state <= S_ERROR;
                end
            endcase
        end
    end

`ifdef PCAP_STATS_EN
    logic [15:0] r_pkt_count;
    logic [15:0] r_drop_count;
    logic        w_drop_enter;

    assign w_drop_enter = reset && w_accept && w_rec_done && (r_len != '0) && w_len_over;
    assign pkt_count    = r_pkt_count;
    assign drop_count   = r_drop_count;

    // Saturating counters of forwarded frames and dropped oversize records
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pkt_count  <= 16'd0;
            r_drop_count <= 16'd0;
        end else begin
            if (out_wr_eof && (r_pkt_count != 16'hFFFF)) begin
                r_pkt_count <= r_pkt_count + 16'd1;
            end
            if (w_drop_enter && (r_drop_count != 16'hFFFF)) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pcap_frame_extract.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pcap_frame_extract
//  Description : Directed stimulus for pcap_frame_extract with a scoreboard
//                queue of expected FIFO writes and an independent monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pcap_frame_extract;

    localparam int MAX_LEN = 1518;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_wr_en;
    logic [7:0] out_din;
    logic       out_wr_sof;
    logic       out_wr_eof;
    logic       out_full;
    logic       hdr_error;
`ifdef PCAP_STATS_EN
    logic [15:0] pkt_count;
    logic [15:0] drop_count;
`endif

    int total = 0;
    int bad   = 0;

    // Expected writes as {sof, eof, data}
    logic [9:0] exp_q[$];

    pcap_frame_extract #(
        .MAX_LEN(MAX_LEN),
        .LEN_W  (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_wr_en (out_wr_en),
        .out_din   (out_din),
        .out_wr_sof(out_wr_sof),
        .out_wr_eof(out_wr_eof),
        .out_full  (out_full),
        .hdr_error (hdr_error)
`ifdef PCAP_STATS_EN
        ,
        .pkt_count (pkt_count),
        .drop_count(drop_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every write strobe must match the next expected entry
    always @(negedge clk) begin
        if (out_wr_en === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write actual={sof=%b eof=%b d=%h} required=no write",
                         out_wr_sof, out_wr_eof, out_din);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                if ({out_wr_sof, out_wr_eof, out_din} !== e) begin
                    bad++;
                    $display("FAIL write_data actual={sof=%b eof=%b d=%h} required={sof=%b eof=%b d=%h}",
                             out_wr_sof, out_wr_eof, out_din, e[9], e[8], e[7:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        out_full = 1'b0;
        reset    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Present one byte and hold it until accepted; waited = stall cycles
    task automatic send_byte(input logic [7:0] b, output int waited);
        waited   = 0;
        in_valid = 1'b1;
        in_data  = b;
        forever begin
            @(negedge clk);
            if (in_ready === 1'b1) break;
            waited++;
            if (waited > 200) begin
                total++;
                bad++;
                $display("FAIL accept_timeout actual=stalled required=accept");
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_global(input logic [7:0] b0);
        logic [7:0] hdr[24];
        int w;
        hdr = '{8'hD4, 8'hC3, 8'hB2, 8'hA1, 8'h02, 8'h00, 8'h04, 8'h00,
                8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                8'hFF, 8'hFF, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
        hdr[0] = b0;
        for (int i = 0; i < 24; i++) send_byte(hdr[i], w);
    endtask

    // Send one record; payload byte i = base+i. Only the first stop_at payload
    // bytes are sent. full_at selects a payload byte that first sees 5 full cycles.
    task automatic send_record(input int len, input int base, input int stop_at,
                               input int full_at, output int stalls);
        int  w;
        bit  fwd;
        logic [7:0] b;
        logic [31:0] l;
        stalls = 0;
        l = len;
        for (int i = 0; i < 8; i++) send_byte(8'(8'h30 + i), w);
        for (int i = 0; i < 4; i++) send_byte(l[8*i +: 8], w);
        for (int i = 0; i < 4; i++) send_byte(l[8*i +: 8], w);
        fwd = (len >= 1) && (len <= MAX_LEN);
        for (int i = 0; (i < len) && (i < stop_at); i++) begin
            b = 8'(base + i);
            if (fwd) exp_q.push_back({(i == 0), (i == len - 1), b});
            if (i == full_at) begin
                in_valid = 1'b1;
                in_data  = b;
                out_full = 1'b1;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    check("full_in_ready", {31'd0, in_ready}, 32'd0);
                    check("full_wr_en", {31'd0, out_wr_en}, 32'd0);
                    @(posedge clk);
                    #1;
                end
                out_full = 1'b0;
            end
            send_byte(b, w);
            stalls += w;
        end
    endtask

    initial begin
        int st;
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        out_full = 1'b0;
        do_reset();

        // Reset state
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_wr_en", {31'd0, out_wr_en}, 32'd0);
        check("rst_sof_eof", {30'd0, out_wr_sof, out_wr_eof}, 32'd0);
        check("rst_hdr_error", {31'd0, hdr_error}, 32'd0);
`ifdef PCAP_STATS_EN
        check("rst_pkt_count", {16'd0, pkt_count}, 32'd0);
        check("rst_drop_count", {16'd0, drop_count}, 32'd0);
`endif
        @(posedge clk);
        #1;

        // One 60-byte record; payload equals stream offsets 40..99
        send_global(8'hD4);
        send_record(60, 40, 60, -1, st);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("t1_all_written", exp_q.size(), 32'd0);

        // Bad magic: error latches, rest of stream is discarded
        do_reset();
        send_global(8'hA1);
        check("t2_hdr_error", {31'd0, hdr_error}, 32'd1);
        send_record(20, 8'h50, 20, -1, st);
        exp_q.delete();
        check("t2_stall_in_error", st, 32'd0);
        check("t2_hdr_error_sticky", {31'd0, hdr_error}, 32'd1);

        // Recovery after reset; then 64B, 0B, 1B back-to-back
        do_reset();
        check("t3_hdr_error_clr", {31'd0, hdr_error}, 32'd0);
        send_global(8'hD4);
        send_record(64, 8'h10, 64, -1, st);
        send_record(0, 8'h00, 0, -1, st);
        send_record(1, 8'hEE, 1, -1, st);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("t3_all_written", exp_q.size(), 32'd0);

        // Oversize record dropped without stalls, following frame forwarded
        do_reset();
        send_global(8'hD4);
        send_record(1600, 8'h00, 1600, -1, st);
        check("t4_drop_stalls", st, 32'd0);
        send_record(64, 8'hA0, 64, -1, st);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("t4_all_written", exp_q.size(), 32'd0);
`ifdef PCAP_STATS_EN
        check("t4_pkt_count", {16'd0, pkt_count}, 32'd1);
        check("t4_drop_count", {16'd0, drop_count}, 32'd1);
`endif

        // Backpressure at payload byte 10
        do_reset();
        send_global(8'hD4);
        send_record(60, 8'h70, 60, 10, st);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("t5_all_written", exp_q.size(), 32'd0);

        // Reset at payload byte 30 of 60, then a fresh stream
        do_reset();
        send_global(8'hD4);
        send_record(60, 8'hC0, 30, -1, st);
        in_valid = 1'b1;
        in_data  = 8'hC0 + 8'd30;
        reset    = 1'b0;
        @(negedge clk);
        check("t6_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("t6_rst_wr_en", {31'd0, out_wr_en}, 32'd0);
        check("t6_rst_sof_eof", {30'd0, out_wr_sof, out_wr_eof}, 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        check("t6_partial_written", exp_q.size(), 32'd0);
        send_global(8'hD4);
        send_record(60, 8'h05, 60, -1, st);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("t6_all_written", exp_q.size(), 32'd0);
        check("t6_hdr_error", {31'd0, hdr_error}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit
    initial begin
        #800000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
